pe_feeder: RTL and testbench



---
 rtl/pe_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_pe_feeder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// pe_feeder: upstream sequencer for the 3-tap row PE.
// Latches a weight triplet, then streams each row of pixels into the PE as a
// sliding 2-deep window (i0 = previous pixel, i1 = newest pixel). It also
// drives the PE mux selects from a per-column schedule and flushes the PE
// pipeline after every row. Every PE-facing output is registered.
//
// Optional feature: define PE_FEEDER_ZPAD_EN to add one leading and one
// trailing zero column to every row, giving ROW_LEN+2 columns per row.
module pe_feeder #(
  parameter int N       = 8,
  parameter int ROW_LEN = 8,
  parameter int ROWS    = 4,
  parameter int DRAIN   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic [3*N-1:0] w_data,
  input  logic           px_valid,
  output logic           px_ready,
  input  logic [N-1:0]   px_data,
  output logic [N-1:0]   i0,
  output logic [N-1:0]   i1,
  output logic [N-1:0]   w0,
  output logic [N-1:0]   w1,
  output logic [N-1:0]   w2,
  output logic           select_m0,
  output logic           select_m1,
  output logic           select_m2,
  output logic           select_m3,
  output logic           select0,
  output logic           select1,
  output logic           pe_valid,
  output logic           row_done,
  output logic           busy
);

`ifdef PE_FEEDER_ZPAD_EN
  // Padded row: column 0 and column ROW_LEN+1 are injected zeros.
  localparam int COLS = ROW_LEN + 2;
`else
  localparam int COLS = ROW_LEN;
`endif

  localparam int COL_W = (COLS > 1)  ? $clog2(COLS)  : 1;
  localparam int ROW_W = (ROWS > 1)  ? $clog2(ROWS)  : 1;
  localparam int DRN_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;

`ifdef PE_FEEDER_ZPAD_EN
  // Column index of the last real pixel, and of the trailing zero column.
  localparam logic [COL_W-1:0] PX_LAST  = COL_W'(ROW_LEN);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
`else
  localparam logic [COL_W-1:0] PX_LAST  = COL_W'(ROW_LEN - 1);
`endif
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [DRN_W-1:0] drn;
  // Packed as {m0, m1, m2, m3, sel1, sel0}.
  logic [5:0]       sel_q;

  // Fixed PE mux schedule: first column, second column, steady state.
  function automatic logic [5:0] schedule(input logic [COL_W-1:0] c);
    if (c == '0) begin
      return 6'b100000;
    end else if (c == COL_W'(1)) begin
      return 6'b011001;
    end else begin
      return 6'b011110;
    end
  endfunction

  assign {select_m0, select_m1, select_m2, select_m3, select1, select0} = sel_q;

  // Sequencer FSM; all outputs are registered here so they feed the PE buffer directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      col      <= '0;
      row      <= '0;
      drn      <= '0;
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      i0       <= '0;
      i1       <= '0;
      sel_q    <= '0;
      pe_valid <= 1'b0;
      row_done <= 1'b0;
      w_ready  <= 1'b1;
      px_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      pe_valid <= 1'b0;
      row_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (w_valid && w_ready) begin
            {w2, w1, w0} <= w_data;
            col          <= '0;
            row          <= '0;
            i0           <= '0;
            i1           <= '0;
            w_ready      <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_STREAM;
`ifdef PE_FEEDER_ZPAD_EN
            px_ready     <= 1'b0;
`else
            px_ready     <= 1'b1;
`endif
          end
        end

        ST_STREAM: begin
`ifdef PE_FEEDER_ZPAD_EN
          if (!px_ready) begin
            i0       <= i1;
            i1       <= '0;
            pe_valid <= 1'b1;
            sel_q    <= schedule(col);
            if (col == COL_LAST) begin
              col   <= '0;
              drn   <= '0;
              state <= ST_DRAIN;
            end else begin
              col      <= col + COL_W'(1);
              px_ready <= 1'b1;
            end
          end else
`endif
          if (px_valid && px_ready) begin
            i0       <= i1;
            i1       <= px_data;
            pe_valid <= 1'b1;
            sel_q    <= schedule(col);
            if (col == PX_LAST) begin
              px_ready <= 1'b0;
`ifdef PE_FEEDER_ZPAD_EN
              col      <= col + COL_W'(1);
`else
              col      <= '0;
              drn      <= '0;
              state    <= ST_DRAIN;
`endif
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end

        ST_DRAIN: begin
          if (drn == DRN_LAST) begin
            drn   <= '0;
            state <= ST_DONE;
          end else begin
            drn <= drn + DRN_W'(1);
          end
        end

        ST_DONE: begin
          row_done <= 1'b1;
          if (row == ROW_LAST) begin
            row     <= '0;
            w_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            row      <= row + ROW_W'(1);
            col      <= '0;
            i0       <= '0;
            i1       <= '0;
            state    <= ST_STREAM;
`ifdef PE_FEEDER_ZPAD_EN
            px_ready <= 1'b0;
`else
            px_ready <= 1'b1;
`endif
          end
        end

        default: begin
          state    <= ST_IDLE;
          w_ready  <= 1'b1;
          px_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: scoreboard bench for pe_feeder. The stimulus pushes each
// expected PE column when it issues pixels; a monitor pops and compares
// whenever pe_valid is high. Handles PE_FEEDER_ZPAD_EN builds too.
module tb_pe_feeder;

  localparam int N       = 8;
  localparam int ROW_LEN = 8;
  localparam int ROWS    = 2;
  localparam int DRAIN   = 2;
`ifdef PE_FEEDER_ZPAD_EN
  localparam int COLS_PER_ROW   = ROW_LEN + 2;
  localparam int PX_READY_ENTRY = 0;
`else
  localparam int COLS_PER_ROW   = ROW_LEN;
  localparam int PX_READY_ENTRY = 1;
`endif

  logic           clk;
  logic           reset_n;
  logic           w_valid;
  logic           w_ready;
  logic [3*N-1:0] w_data;
  logic           px_valid;
  logic           px_ready;
  logic [N-1:0]   px_data;
  logic [N-1:0]   i0;
  logic [N-1:0]   i1;
  logic [N-1:0]   w0;
  logic [N-1:0]   w1;
  logic [N-1:0]   w2;
  logic           select_m0;
  logic           select_m1;
  logic           select_m2;
  logic           select_m3;
  logic           select0;
  logic           select1;
  logic           pe_valid;
  logic           row_done;
  logic           busy;

  typedef struct packed {
    logic [N-1:0] i0;
    logic [N-1:0] i1;
    logic [5:0]   sel;
  } col_t;

  col_t           sb[$];
  int             nCompared   = 0;
  int             nMismatched = 0;
  int             rowsSeen    = 0;
  logic [3*N-1:0] expW;
  logic [N-1:0]   modelPrev;
  int             modelCol;

  pe_feeder #(
    .N(N),
    .ROW_LEN(ROW_LEN),
    .ROWS(ROWS),
    .DRAIN(DRAIN)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data(w_data),
    .px_valid(px_valid),
    .px_ready(px_ready),
    .px_data(px_data),
    .i0(i0),
    .i1(i1),
    .w0(w0),
    .w1(w1),
    .w2(w2),
    .select_m0(select_m0),
    .select_m1(select_m1),
    .select_m2(select_m2),
    .select_m3(select_m3),
    .select0(select0),
    .select1(select1),
    .pe_valid(pe_valid),
    .row_done(row_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written select table {m0,m1,m2,m3,sel1,sel0} by column.
  function automatic logic [5:0] expSel(input int c);
    if (c == 0) return 6'b100000;
    if (c == 1) return 6'b011001;
    return 6'b011110;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected column: i1 is the new value, i0 the previous one in the row.
  task automatic pushCol(input logic [N-1:0] v);
    col_t e;
    e.i0 = modelPrev;
    e.i1 = v;
    e.sel = expSel(modelCol);
    sb.push_back(e);
    modelPrev = v;
    modelCol++;
  endtask

  task automatic startRow();
    modelPrev = '0;
    modelCol  = 0;
`ifdef PE_FEEDER_ZPAD_EN
    pushCol('0);
`endif
  endtask

  task automatic finishRow();
`ifdef PE_FEEDER_ZPAD_EN
    pushCol('0);
`endif
  endtask

  task automatic loadWeights(input logic [3*N-1:0] data);
    expW = data;
    startRow();
    w_valid = 1'b1;
    w_data  = data;
    @(negedge clk);
    w_valid = 1'b0;
    w_data  = '0;
    checkOutput("load_w0", 32'(w0), 32'(data[N-1:0]));
    checkOutput("load_w1", 32'(w1), 32'(data[2*N-1:N]));
    checkOutput("load_w2", 32'(w2), 32'(data[3*N-1:2*N]));
    checkOutput("load_busy", 32'(busy), 1);
    checkOutput("load_w_ready", 32'(w_ready), 0);
    checkOutput("load_px_ready", 32'(px_ready), PX_READY_ENTRY);
  endtask

  // Offer one pixel until accepted, then leave 'gap' idle cycles checking the hold.
  task automatic applyStimulus(input logic [N-1:0] p, input int gap);
    int waited;
    pushCol(p);
    px_valid = 1'b1;
    px_data  = p;
    waited   = 0;
    while (px_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("px_ready_before_handshake", 32'(px_ready), 1);
    @(negedge clk);
    px_valid = 1'b0;
    px_data  = '0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      checkOutput("gap_pe_valid", 32'(pe_valid), 0);
      checkOutput("gap_i1_hold", 32'(i1), 32'(p));
    end
  endtask

  // Monitor: pops the scoreboard on every PE column and checks row_done framing.
  initial begin : monitor
    col_t e;
    int   gap;
    int   colsInRow;
    gap       = 0;
    colsInRow = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        gap       = 0;
        colsInRow = 0;
      end else begin
        if (row_done === 1'b1) begin
          rowsSeen++;
          checkOutput("row_done_drain_gap", 32'(gap), 32'(DRAIN));
          checkOutput("row_done_col_count", 32'(colsInRow), 32'(COLS_PER_ROW));
          colsInRow = 0;
        end
        if (pe_valid === 1'b1) begin
          if (sb.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_column: got i0=0x%0h i1=0x%0h, expected no column", i0, i1);
          end else begin
            e = sb.pop_front();
            checkOutput("col_i0", 32'(i0), 32'(e.i0));
            checkOutput("col_i1", 32'(i1), 32'(e.i1));
            checkOutput("col_sel",
                        32'({select_m0, select_m1, select_m2, select_m3, select1, select0}),
                        32'(e.sel));
            checkOutput("col_weights", 32'({w2, w1, w0}), 32'(expW));
          end
          gap = 0;
          colsInRow++;
        end else begin
          gap++;
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int waited;
    reset_n   = 1'b0;
    w_valid   = 1'b0;
    w_data    = '0;
    px_valid  = 1'b0;
    px_data   = '0;
    expW      = '0;
    modelPrev = '0;
    modelCol  = 0;

    repeat (3) @(negedge clk);
    $display("[TB] checking reset state");
    checkOutput("rst_w_ready", 32'(w_ready), 1);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_px_ready", 32'(px_ready), 0);
    checkOutput("rst_pe_valid", 32'(pe_valid), 0);
    checkOutput("rst_row_done", 32'(row_done), 0);
    checkOutput("rst_i0", 32'(i0), 0);
    checkOutput("rst_i1", 32'(i1), 0);
    checkOutput("rst_weights", 32'({w2, w1, w0}), 0);
    checkOutput("rst_selects", 32'({select_m0, select_m1, select_m2, select_m3, select1, select0}), 0);

    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_w_ready", 32'(w_ready), 1);

    $display("[TB] row 1: weights 030201, pixels 10..17, spurious w_valid");
    loadWeights(24'h030201);
    w_valid = 1'b1;
    w_data  = 24'hAABBCC;
    for (int k = 0; k < ROW_LEN; k++) applyStimulus(N'(10 + k), 0);
    finishRow();
    w_valid = 1'b0;
    w_data  = '0;
    checkOutput("weights_ignore_reload", 32'({w2, w1, w0}), 32'h030201);

    $display("[TB] row 2: backpressure after first pixel");
    startRow();
    applyStimulus(N'(20), 2);
    for (int k = 1; k < ROW_LEN; k++) applyStimulus(N'(20 + k), 0);
    finishRow();

    waited = 0;
    while (w_ready !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("return_idle_w_ready", 32'(w_ready), 1);
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("idle_px_ready", 32'(px_ready), 0);
    checkOutput("rows_after_two", 32'(rowsSeen), 2);
    checkOutput("weights_held_in_idle", 32'({w2, w1, w0}), 32'h030201);
    checkOutput("sb_empty_after_rows", 32'(sb.size()), 0);

    $display("[TB] abort: reset mid-row");
    loadWeights(24'h060504);
    applyStimulus(N'(30), 0);
    applyStimulus(N'(31), 0);
    applyStimulus(N'(32), 0);
    @(negedge clk);
    checkOutput("sb_empty_pre_abort", 32'(sb.size()), 0);
    #2 reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_w_ready", 32'(w_ready), 1);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_i0", 32'(i0), 0);
    checkOutput("abort_i1", 32'(i1), 0);
    checkOutput("abort_weights", 32'({w2, w1, w0}), 0);
    checkOutput("abort_pe_valid", 32'(pe_valid), 0);
    checkOutput("abort_row_done", 32'(row_done), 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("no_row_done_after_abort", 32'(rowsSeen), 2);
    checkOutput("abort_stays_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
